// File: rtl/deadlock_rpt_pkg.sv
// Shared types, widths and the round-robin search helper for the deadlock
// report controller.
package deadlock_rpt_pkg;

    localparam int CNT_W   = 8;
    localparam int TIME_W  = 32;
    localparam int MAX_MON = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        REPORT = 1'b1
    } rpt_state_e;

    // Returns {found, index} of the first set bit of req, starting at last+1
    // and wrapping inside [0, num). Bits at or above num are never looked at.
    function automatic logic [4:0] rr_first(input logic [MAX_MON-1:0] req,
                                            input int last,
                                            input int num);
        logic [4:0] res;
        int         idx;
        res = '0;
        // Walk from the farthest candidate to the nearest so the nearest
        // set bit is the one left in res.
        for (int k = MAX_MON; k >= 1; k--) begin
            if (k <= num) begin
                idx = last + k;
                if (idx >= num) begin
                    idx = idx - num;
                end
                if (req[idx[3:0]]) begin
                    res = {1'b1, idx[3:0]};
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/deadlock_persist_cnt.sv
// Per-monitor persistence qualifier: counts consecutive enabled blocked
// cycles and emits a single-cycle set pulse once per continuous block event.
module deadlock_persist_cnt
    import deadlock_rpt_pkg::*;
#(
    parameter int THRESH = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    input  logic block,
    output logic set_pulse
);

    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] CNT_TRIG = CNT_W'(THRESH - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             armed_q;

    // The pulse fires on the edge that would complete THRESH blocked cycles.
    assign set_pulse = enable && block && armed_q && (cnt_q == CNT_TRIG);

    // Saturating count while blocked; re-arm only once the block goes away.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            armed_q <= 1'b1;
        end else if (enable && block) begin
            if (cnt_q != CNT_SAT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (set_pulse) begin
                armed_q <= 1'b0;
            end
        end else begin
            cnt_q   <= '0;
            armed_q <= 1'b1;
        end
    end

endmodule

// File: rtl/deadlock_report_ctrl.sv
// Collects persistent block events from the dataflow monitors, arbitrates
// round-robin among them and hands out one report at a time.
// Handshake: a report transfers on any rising edge where rpt_valid and
// rpt_ready are both high; rpt_idx/rpt_info/rpt_time stay stable while
// rpt_valid is high and not yet accepted, and rpt_valid never drops before
// the transfer (except by reset).
module deadlock_report_ctrl
    import deadlock_rpt_pkg::*;
#(
    parameter int NUM_MON = 2,
    parameter int INFO_W  = 9,
    parameter int THRESH  = 16,
    parameter int IDX_W   = 4
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic [NUM_MON-1:0]          mon_block,
    input  logic [NUM_MON*INFO_W-1:0]   mon_info,
    output logic                        rpt_valid,
    input  logic                        rpt_ready,
    output logic [IDX_W-1:0]            rpt_idx,
    output logic [INFO_W-1:0]           rpt_info,
    output logic [TIME_W-1:0]           rpt_time,
    output logic [NUM_MON-1:0]          pending,
    output logic                        deadlock_irq,
    input  logic                        irq_clear,
    output rpt_state_e                  dbg_state
);

    rpt_state_e          state_q, state_d;
    logic [NUM_MON-1:0]  set_vec;
    logic [NUM_MON-1:0]  clr_vec;
    logic [IDX_W-1:0]    last_grant_q;
    logic [TIME_W-1:0]   cycle_q;
    logic [MAX_MON-1:0]  req_ext;
    logic [4:0]          rr_res;
    logic [3:0]          grant;
    logic                grant_found;
    logic [INFO_W-1:0]   grant_info;
    logic                capture;
    logic                accept;

    genvar g;
    generate
        for (g = 0; g < NUM_MON; g++) begin : g_mon
            deadlock_persist_cnt #(
                .THRESH (THRESH)
            ) u_persist (
                .clock     (clock),
                .reset_n   (reset_n),
                .enable    (enable),
                .block     (mon_block[g]),
                .set_pulse (set_vec[g])
            );
        end
    endgenerate

    assign rpt_valid = (state_q == REPORT);
    assign dbg_state = state_q;

    // Round-robin pick among pending monitors and mux out the winner's info.
    always_comb begin
        req_ext              = '0;
        req_ext[NUM_MON-1:0] = pending;
        rr_res               = rr_first(req_ext, int'(last_grant_q), NUM_MON);
        grant                = rr_res[3:0];
        grant_found          = rr_res[4];
        grant_info           = '0;
        for (int i = 0; i < NUM_MON; i++) begin
            if (grant == 4'(i)) begin
                grant_info = mon_info[i*INFO_W +: INFO_W];
            end
        end
    end

    // Report FSM next state: capture from IDLE, wait for acceptance in REPORT.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    capture = 1'b1;
                    state_d = REPORT;
                end
            end
            REPORT: begin
                if (rpt_ready) begin
                    accept  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Decode the pending bit retired by an accepted report.
    always_comb begin
        clr_vec = '0;
        for (int i = 0; i < NUM_MON; i++) begin
            if (accept && (rpt_idx == IDX_W'(i))) begin
                clr_vec[i] = 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Report payload capture and round-robin pointer update.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rpt_idx      <= '0;
            rpt_info     <= '0;
            rpt_time     <= '0;
            last_grant_q <= IDX_W'(NUM_MON - 1);
        end else begin
            if (capture) begin
                rpt_idx  <= IDX_W'(grant);
                rpt_info <= grant_info;
                rpt_time <= cycle_q;
            end
            if (accept) begin
                last_grant_q <= rpt_idx;
            end
        end
    end

    // Pending set/clear; a set and a clear never target the same bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
        end else begin
            pending <= (pending | set_vec) & ~clr_vec;
        end
    end

    // Sticky interrupt; a new event beats a simultaneous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            deadlock_irq <= 1'b0;
        end else if (|set_vec) begin
            deadlock_irq <= 1'b1;
        end else if (irq_clear) begin
            deadlock_irq <= 1'b0;
        end
    end

    // Free-running timestamp counter, wraps naturally.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + TIME_W'(1);
        end
    end

endmodule

// File: tb/tb_deadlock_report_ctrl.sv
// Bench for deadlock_report_ctrl: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// behavioural model built from run lengths and a pending set.
module tb_deadlock_report_ctrl;
    import deadlock_rpt_pkg::*;

    localparam int NUM_MON = 2;
    localparam int INFO_W  = 9;
    localparam int THRESH  = 4;
    localparam int IDX_W   = 4;

    logic                      clock = 1'b0;
    logic                      reset_n = 1'b0;
    logic                      enable = 1'b0;
    logic [NUM_MON-1:0]        mon_block = '0;
    logic [NUM_MON*INFO_W-1:0] mon_info = '0;
    logic                      rpt_ready = 1'b0;
    logic                      irq_clear = 1'b0;
    logic                      rpt_valid;
    logic [IDX_W-1:0]          rpt_idx;
    logic [INFO_W-1:0]         rpt_info;
    logic [31:0]               rpt_time;
    logic [NUM_MON-1:0]        pending;
    logic                      deadlock_irq;
    rpt_state_e                dbg_state;

    int checks = 0;
    int errors = 0;
    int hs_count = 0;

    // Model state
    int                 m_run [NUM_MON];
    bit                 m_fired [NUM_MON];
    logic [NUM_MON-1:0] m_pending;
    bit                 m_busy;
    int                 m_idx;
    logic [INFO_W-1:0]  m_info;
    logic [31:0]        m_time;
    logic [31:0]        m_cycle;
    int                 m_last;
    bit                 m_irq;

    deadlock_report_ctrl #(
        .NUM_MON (NUM_MON),
        .INFO_W  (INFO_W),
        .THRESH  (THRESH),
        .IDX_W   (IDX_W)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .mon_block    (mon_block),
        .mon_info     (mon_info),
        .rpt_valid    (rpt_valid),
        .rpt_ready    (rpt_ready),
        .rpt_idx      (rpt_idx),
        .rpt_info     (rpt_info),
        .rpt_time     (rpt_time),
        .pending      (pending),
        .deadlock_irq (deadlock_irq),
        .irq_clear    (irq_clear),
        .dbg_state    (dbg_state)
    );

    // Clock
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_MON; i++) begin
            m_run[i]   = 0;
            m_fired[i] = 1'b0;
        end
        m_pending = '0;
        m_busy    = 1'b0;
        m_idx     = 0;
        m_info    = '0;
        m_time    = '0;
        m_cycle   = '0;
        m_last    = NUM_MON - 1;
        m_irq     = 1'b0;
    endtask

    // Model: an event fires on the THRESH-th consecutive enabled blocked
    // cycle of a run; reports go out one at a time in rotating order.
    task automatic model_step();
        logic [NUM_MON-1:0] old_pend;
        logic [NUM_MON-1:0] sets;
        logic [NUM_MON-1:0] clr;
        bit                 got;
        int                 j;
        old_pend = m_pending;
        sets     = '0;
        clr      = '0;
        for (int i = 0; i < NUM_MON; i++) begin
            if (enable && mon_block[i]) begin
                if (m_run[i] <= THRESH) m_run[i]++;
                if (m_run[i] == THRESH && !m_fired[i]) begin
                    sets[i]    = 1'b1;
                    m_fired[i] = 1'b1;
                end
            end else begin
                m_run[i]   = 0;
                m_fired[i] = 1'b0;
            end
        end
        if (m_busy) begin
            if (rpt_ready) begin
                clr[m_idx] = 1'b1;
                m_last     = m_idx;
                m_busy     = 1'b0;
            end
        end else if (old_pend != '0) begin
            got = 1'b0;
            for (int k = 1; k <= NUM_MON; k++) begin
                j = (m_last + k) % NUM_MON;
                if (!got && old_pend[j]) begin
                    got    = 1'b1;
                    m_idx  = j;
                    m_info = mon_info[j*INFO_W +: INFO_W];
                    m_time = m_cycle;
                    m_busy = 1'b1;
                end
            end
        end
        m_pending = (old_pend | sets) & ~clr;
        if (sets != '0) m_irq = 1'b1;
        else if (irq_clear) m_irq = 1'b0;
        m_cycle = m_cycle + 32'd1;
    endtask

    // Advance the model on every active edge out of reset.
    always @(posedge clock) begin
        if (reset_n) model_step();
    end

    // Compare DUT outputs with the model on every falling edge.
    always @(negedge clock) begin
        if (reset_n) begin
            check("rpt_valid", rpt_valid, m_busy);
            check("dbg_state", (dbg_state == REPORT), m_busy);
            if (m_busy) begin
                check("rpt_idx", rpt_idx, m_idx);
                check("rpt_info", rpt_info, m_info);
                check("rpt_time", rpt_time, m_time);
            end
            check("pending", pending, m_pending);
            check("deadlock_irq", deadlock_irq, m_irq);
            if (rpt_valid && rpt_ready) hs_count++;
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset_n   = 1'b0;
        mon_block = '0;
        irq_clear = 1'b0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Stimulus
    initial begin
        model_reset();
        repeat (3) @(negedge clock);
        check("reset_valid", rpt_valid, 0);
        check("reset_pending", pending, 0);
        check("reset_irq", deadlock_irq, 0);
        check("reset_idx", rpt_idx, 0);
        check("reset_info", rpt_info, 0);
        check("reset_time", rpt_time, 0);
        reset_n = 1'b1;

        // Basic report
        enable    = 1'b1;
        rpt_ready = 1'b1;
        mon_info  = {9'h0AB, 9'h1FE};
        mon_block = 2'b01;
        repeat (4) tick();
        check("basic_pending", pending, 2'b01);
        check("basic_irq", deadlock_irq, 1);
        tick();
        check("basic_valid", rpt_valid, 1);
        check("basic_idx", rpt_idx, 0);
        check("basic_info", rpt_info, 9'h1FE);
        check("basic_time", rpt_time, 4);
        tick();
        check("basic_valid_drop", rpt_valid, 0);
        check("basic_pending_clr", pending, 2'b00);
        mon_block = 2'b00;
        repeat (2) tick();

        // Glitch rejection
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        check("glitch_irq_pre", deadlock_irq, 0);
        mon_block = 2'b01; repeat (3) tick();
        mon_block = 2'b00; tick();
        mon_block = 2'b01; repeat (3) tick();
        mon_block = 2'b00; tick();
        check("glitch_pending", pending, 0);
        check("glitch_irq", deadlock_irq, 0);

        // Round-robin
        do_reset();
        enable    = 1'b1;
        rpt_ready = 1'b0;
        mon_block = 2'b11;
        repeat (4) tick();
        check("rr_pending", pending, 2'b11);
        tick();
        check("rr_first_valid", rpt_valid, 1);
        check("rr_first_idx", rpt_idx, 0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("rr_hold_valid", rpt_valid, 1);
            check("rr_hold_idx", rpt_idx, 0);
        end
        rpt_ready = 1'b1;
        tick();
        check("rr_gap_valid", rpt_valid, 0);
        check("rr_gap_pending", pending, 2'b10);
        tick();
        check("rr_second_valid", rpt_valid, 1);
        check("rr_second_idx", rpt_idx, 1);
        tick();
        check("rr_drained", pending, 2'b00);
        mon_block = 2'b00; tick();
        mon_block = 2'b11; repeat (4) tick();
        check("rr_re_pending", pending, 2'b11);
        tick();
        check("rr_third_idx", rpt_idx, 0);
        mon_block = 2'b00;
        repeat (5) tick();

        // Single report per event
        hs_count  = 0;
        mon_block = 2'b10;
        repeat (100) tick();
        check("single_count", hs_count, 1);
        mon_block = 2'b00; tick();
        mon_block = 2'b10; repeat (4) tick();
        mon_block = 2'b00; repeat (3) tick();
        check("second_count", hs_count, 2);

        // irq priority
        irq_clear = 1'b1; tick(); irq_clear = 1'b0;
        check("irq_cleared", deadlock_irq, 0);
        mon_block = 2'b01;
        repeat (3) tick();
        irq_clear = 1'b1; tick(); irq_clear = 1'b0;
        check("irq_set_wins", deadlock_irq, 1);
        check("irq_pending", pending, 2'b01);
        mon_block = 2'b00;
        repeat (4) tick();
        irq_clear = 1'b1; tick(); irq_clear = 1'b0;
        check("irq_clear_late", deadlock_irq, 0);

        // enable low
        enable    = 1'b0;
        mon_block = 2'b11;
        repeat (50) tick();
        check("enable_pending", pending, 0);
        check("enable_irq", deadlock_irq, 0);
        mon_block = 2'b00;
        enable    = 1'b1;
        tick();

        // Randomized phase
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NUM_MON; i++) begin
                if ($urandom_range(0, 7) == 0) mon_block[i] = ~mon_block[i];
            end
            enable    = ($urandom_range(0, 19) != 0);
            rpt_ready = ($urandom_range(0, 2) != 0);
            irq_clear = ($urandom_range(0, 15) == 0);
            mon_info  = NUM_MON*INFO_W'($urandom);
            tick();
        end

        // Async reset mid-report
        enable    = 1'b1;
        irq_clear = 1'b0;
        mon_block = 2'b00;
        rpt_ready = 1'b1;
        repeat (8) tick();
        rpt_ready = 1'b0;
        mon_block = 2'b01;
        repeat (5) tick();
        check("async_pre_valid", rpt_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_valid", rpt_valid, 0);
        check("async_pending", pending, 0);
        check("async_irq", deadlock_irq, 0);
        model_reset();
        mon_block = 2'b00;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/deadlock_report_ctrl.md
Name: deadlock_report_ctrl

Overview:
- Sits above the per-dataflow deadlock monitors and collects their `block` and `axis_block_info` outputs.
- Qualifies each monitor's block as persistent (N consecutive cycles) and arbitrates round-robin among pending monitors.
- Emits one report per event over a valid/ready interface, plus a sticky interrupt for the host/debug logic.

Parameters:
- NUM_MON, 2, number of monitor inputs (1..16).
- INFO_W, 9, width of each monitor's axis_block_info vector.
- THRESH, 16, consecutive blocked cycles required to qualify (2..255).
- IDX_W, 4, width of the reported monitor index; must satisfy 2^IDX_W >= NUM_MON.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  qualification enable.
- mon_block  in  NUM_MON  block output of each monitor; bit i = monitor i.
- mon_info  in  NUM_MON*INFO_W  axis_block_info of each monitor; slice [i*INFO_W +: INFO_W].
- rpt_valid  out  1  report available.
- rpt_ready  in  1  consumer accepts report.
- rpt_idx  out  IDX_W  index of the reported monitor.
- rpt_info  out  INFO_W  captured info of the reported monitor.
- rpt_time  out  32  free-running cycle count at capture.
- pending  out  NUM_MON  monitors qualified but not yet reported.
- deadlock_irq  out  1  sticky interrupt.
- irq_clear  in  1  single-cycle clear of deadlock_irq.

Behaviour:
- Reset (async assert, sync release) clears everything to 0: cnt[i], armed[i]=1, pending, FSM=IDLE, last_grant=NUM_MON-1, rpt_*, deadlock_irq, cycle counter.
- Cycle counter: 32-bit, +1 every cycle, wraps 0xFFFFFFFF->0.
- Persistence counter cnt[i], 8 bits:
  - If enable and mon_block[i], cnt[i]++ saturating at THRESH.
  - Otherwise cnt[i]=0 and armed[i]=1.
- pending[i] set on the edge where cnt[i]==THRESH-1, enable, mon_block[i] and armed[i] all hold; the same edge clears armed[i].
  - A monitor re-arms only after mon_block[i] deasserts, so each continuous block event reports once.
- FSM states:
  - IDLE: if |pending, grant the first set bit searching from last_grant+1 upward with wrap. Capture rpt_idx=grant, rpt_info=mon_info[grant] (current cycle), rpt_time=cycle counter. Go to REPORT.
  - REPORT: rpt_valid=1; rpt_idx, rpt_info and rpt_time are held stable. On rpt_valid&&rpt_ready: clear pending[grant], last_grant=grant, go to IDLE. rpt_valid drops the next cycle, so there is at most one report every 2 cycles.
- Latency: mon_block high sampled at edges 1..THRESH -> pending after edge THRESH -> rpt_valid after edge THRESH+1.
- Simultaneous events:
  - A pending set and a pending clear of different bits both take effect.
  - The same bit cannot be set and cleared in one edge, because armed was cleared when it was set.
- deadlock_irq:
  - Set on any edge where a pending bit is set.
  - Cleared by irq_clear.
  - Set wins over a simultaneous clear.
- enable low:
  - Zeroes counters and blocks new pending bits.
  - Existing pending bits and an in-flight report complete normally.
- Reset mid-report: rpt_valid drops asynchronously, and the report is lost; this is the defined behaviour.
- Monitor indices >= NUM_MON never granted; unused rpt_idx bits are 0.

Decomposition:
- Package deadlock_rpt_pkg holds:
  - the FSM state enum {IDLE, REPORT};
  - CNT_W=8 and TIME_W=32;
  - a helper function for the round-robin first-set-from-offset search.
- One sub-module, deadlock_persist_cnt, instantiated NUM_MON times. It owns cnt, armed and the pending-set pulse; the top owns pending, the arbiter, the FSM and the irq.

Test Plan:
- Basic report (THRESH=4, rpt_ready=1): mon_block=01 from edge 1, mon_info[0]=0x1FE.
  - pending=01 and irq=1 after edge 4.
  - rpt_valid=1 after edge 5 with rpt_idx=0, rpt_info=0x1FE.
  - After edge 6: rpt_valid=0 and pending=00.
- Glitch rejection: mon_block[0] high 3 cycles, low 1, high 3 -> pending never set, irq stays 0.
- Round-robin (rpt_ready=0): both monitors qualify on the same edge -> first report idx 0, held stable for 5 cycles. Then raise rpt_ready -> next report idx 1. Re-trigger both -> first grant idx 0 again, since the search starts at last_grant+1 (0) with wrap.
- Single report per event: mon_block[1] held high 100 cycles -> exactly one report. Drop for 1 cycle, raise for 4 cycles -> second report.
- irq priority: irq_clear pulse on the same edge a pending bit is set -> irq remains 1. A later clear with no event -> irq 0.
- enable and async reset: enable=0 with mon_block=11 for 50 cycles -> no pending. Assert reset_n low mid-REPORT -> rpt_valid, pending and irq go 0 immediately without a clock edge.
